// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel receiver for 8E1 frames sent MSB first.
// Frame: start(0), d7..d0, even parity, stop(1). Each bit is sampled at mid-period.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   data_in    - serial line, idles high, asynchronous to clk
//   data_out   - last received byte (held until the next completed frame)
//   rx_valid   - one-cycle strobe per completed frame, errored frames included
//   parity_err - parity mismatch on the last completed frame
//   frame_err  - stop bit sampled low on the last completed frame
//   rx_busy    - frame in progress or waiting for the line to return high
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, rx_s;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             perr_q;
    logic             stop_q;

    logic half_end, bit_end;
    logic cnt_clr, shift_en, par_en, stop_en, commit;

    assign half_end = (cnt_q == HALF_LAST);
    assign bit_end  = (cnt_q == BIT_LAST);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= data_in;
            rx_s    <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (half_end) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (bit_end && (idx_q == 3'd7)) state_d = S_PARITY;
            S_PARITY:    if (bit_end) state_d = S_STOP;
            S_STOP:      if (bit_end) state_d = S_DONE;
            S_DONE:      state_d = stop_q ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE:   cnt_clr = 1'b1;
            S_START:  cnt_clr = half_end;
            S_DATA: begin
                shift_en = bit_end;
                cnt_clr  = bit_end;
            end
            S_PARITY: begin
                par_en  = bit_end;
                cnt_clr = bit_end;
            end
            S_STOP:   stop_en = bit_end;
            S_DONE:   commit  = 1'b1;
            default: ;
        endcase
    end

    // Bit-period counter, bit index and sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
            if (state_q != S_DATA) idx_q <= '0;
            else if (shift_en)     idx_q <= idx_q + 3'd1;
            if (shift_en) shift_q <= {shift_q[6:0], rx_s};
            if (par_en)   perr_q  <= rx_s ^ (^shift_q);
            if (stop_en)  stop_q  <= rx_s;
        end
    end

    // Registered outputs; busy lags the state by one cycle so it drops after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= commit;
            rx_busy  <= (state_q != S_IDLE);
            if (commit) begin
                data_out   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ~stop_q;
            end
        end
    end

endmodule
